// File: rtl/pcie_cfg_arbiter_if.sv
// Request/response and APB bundle between requesters, the config arbiter and the register block.
interface pcie_cfg_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*12-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;

    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [11:0]           paddr;
    logic [31:0]           pwdata;
    logic                  pready;
    logic                  pslverr;
    logic [31:0]           prdata;

    // Arbiter side: APB master towards the register block, responder towards requesters.
    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  pready, pslverr, prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output pready, pslverr, prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/pcie_cfg_arbiter.sv
// Round-robin arbiter serialising requester reads/writes into APB SETUP/ACCESS transfers (optional PCIE_CFG_ARB_TIMEOUT_EN).
// Latency: accept at edge 0, response pulse in cycle 3 + slave wait states; misaligned requests respond in cycle 1.
// Backpressure: one grant per IDLE cycle, combinational one-hot ready; losers hold valid until granted.
module pcie_cfg_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    pcie_cfg_arbiter_if.master bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t             state, state_nxt;
    logic [GW-1:0]      last_grant, grant;
    logic [GW-1:0]      pick;
    logic               pick_vld;
    logic [GW:0]        idx;
    logic               sel_write;
    logic [11:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic               sel_misaligned;

    logic               lat_write;
    logic [11:0]        lat_addr;
    logic [31:0]        lat_wdata;

    logic [NUM_REQ-1:0] req_ready_c;
    logic               rsp_err_c;
    logic [31:0]        rsp_rdata_c;

    logic               psel_q, penable_q, pwrite_q;
    logic [11:0]        paddr_q;
    logic [31:0]        pwdata_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;

`ifdef PCIE_CFG_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0]      to_cnt, to_cnt_nxt;
`endif

    // Round-robin search starting one past the last winner.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, last_grant} + (GW+1)'(k);
            if (idx >= (GW+1)'(NUM_REQ)) begin
                idx = idx - (GW+1)'(NUM_REQ);
            end
            if (!pick_vld && bus.req_valid[idx[GW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == GW'(i)) begin
                sel_write = bus.req_write[i];
                sel_addr  = bus.req_addr[12*i +: 12];
                sel_wdata = bus.req_wdata[32*i +: 32];
            end
        end
        sel_misaligned = (sel_addr[1:0] != 2'b00);
    end

    always_comb begin
        state_nxt   = state;
        req_ready_c = '0;
        rsp_err_c   = 1'b0;
        rsp_rdata_c = '0;
`ifdef PCIE_CFG_ARB_TIMEOUT_EN
        to_cnt_nxt  = to_cnt;
`endif
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    req_ready_c = ONE << pick;
                    if (sel_misaligned) begin
                        state_nxt = RESP;
                        rsp_err_c = 1'b1;
                    end else begin
                        state_nxt = SETUP;
                    end
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
`ifdef PCIE_CFG_ARB_TIMEOUT_EN
                to_cnt_nxt = '0;
`endif
            end
            ACCESS: begin
                if (bus.pready) begin
                    state_nxt   = RESP;
                    rsp_err_c   = bus.pslverr;
                    rsp_rdata_c = (lat_write || bus.pslverr) ? 32'h0 : bus.prdata;
                end
`ifdef PCIE_CFG_ARB_TIMEOUT_EN
                else if (to_cnt == CW'(TIMEOUT_CYC - 1)) begin
                    state_nxt = RESP;
                    rsp_err_c = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
`endif
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Ready is combinational, so it must be masked while reset holds the FSM.
    assign bus.req_ready = rst_n ? req_ready_c : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= GW'(NUM_REQ - 1);
            grant       <= '0;
            lat_write   <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_vld) begin
                last_grant <= pick;
                grant      <= pick;
                lat_write  <= sel_write;
                lat_addr   <= sel_addr;
                lat_wdata  <= sel_wdata;
            end

            psel_q    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
            penable_q <= (state_nxt == ACCESS);
            if (state_nxt == SETUP) begin
                pwrite_q <= sel_write;
                paddr_q  <= sel_addr;
                pwdata_q <= sel_wdata;
            end else if (state_nxt == ACCESS) begin
                pwrite_q <= lat_write;
                paddr_q  <= lat_addr;
                pwdata_q <= lat_wdata;
            end else begin
                pwrite_q <= 1'b0;
                paddr_q  <= '0;
                pwdata_q <= '0;
            end

            // A misaligned request jumps straight from IDLE, before grant has been loaded.
            if (state_nxt == RESP) begin
                rsp_valid_q <= ONE << ((state == IDLE) ? pick : grant);
                rsp_rdata_q <= rsp_rdata_c;
                rsp_err_q   <= rsp_err_c;
            end else begin
                rsp_valid_q <= '0;
                rsp_rdata_q <= '0;
                rsp_err_q   <= 1'b0;
            end
        end
    end

`ifdef PCIE_CFG_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_nxt;
        end
    end
`endif

    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_pcie_cfg_arbiter.sv
// Bench for pcie_cfg_arbiter: directed scenarios plus random requesters and APB slave, checked every cycle
// against a transaction-timeline model (grant cycle + fixed offsets derived from wait states).
`timescale 1ns/1ps
module tb_pcie_cfg_arbiter;
    localparam int N = 4;
    localparam int T = 16;
`ifdef PCIE_CFG_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pcie_cfg_arbiter_if #(.NUM_REQ(N)) bus ();
    pcie_cfg_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: one transaction at a time, described by its grant cycle and response offset.
    logic [31:0] mem [64];
    int          cyc = 0, idle_at = 0, t_acc = 0, rsp_d = 0, t_w = 0, d = 0;
    int          last = N - 1, tg = 0;
    bit          t_mis, t_wr, t_to, t_slv, t_err;
    logic [11:0] t_addr;
    logic [31:0] t_wd, t_prd, t_rd;
    logic [N-1:0] m_ready = '0, hold = '0;
    bit          run = 1'b0, rnd = 1'b0;
    int          force_w = -1, force_err = -1;

    logic [N-1:0] e_ready, e_rsp;
    logic         e_psel, e_pen, e_wr, e_err;
    logic [11:0]  e_addr;
    logic [31:0]  e_wd, e_rd;

    task automatic new_txn();
        t_acc  = cyc;
        last   = tg;
        t_wr   = bus.req_write[tg];
        t_addr = bus.req_addr[12*tg +: 12];
        t_wd   = bus.req_wdata[32*tg +: 32];
        t_mis  = (t_addr[1:0] != 2'b00);
        t_w    = (force_w >= 0) ? force_w : $urandom_range(0, 3);
        t_slv  = (force_err >= 0) ? (force_err != 0) : ($urandom_range(0, 7) == 0);
        t_to   = TO_EN && (t_w >= T);
        t_prd  = mem[t_addr[7:2]];
        if (t_mis) begin
            t_err = 1'b1; rsp_d = 1;
        end else if (t_to) begin
            t_err = 1'b1; rsp_d = 2 + T;
        end else begin
            t_err = t_slv; rsp_d = 3 + t_w;
        end
        t_rd = (!t_wr && !t_err) ? t_prd : 32'h0;
        if (t_wr && !t_err) mem[t_addr[7:2]] = t_wd;
        idle_at = cyc + rsp_d + 1;
    endtask

    always @(negedge clk) begin
        if (run) begin
            cyc++;
            e_ready = '0; e_rsp = '0; e_psel = 0; e_pen = 0; e_wr = 0; e_err = 0;
            e_addr = '0; e_wd = '0; e_rd = '0;
            if (cyc >= idle_at) begin
                for (int k = 1; k <= N; k++) begin
                    if (e_ready == '0 && bus.req_valid[(last + k) % N]) begin
                        tg = (last + k) % N;
                        e_ready[tg] = 1'b1;
                    end
                end
                if (e_ready != '0) new_txn();
            end else begin
                d = cyc - t_acc;
                if (!t_mis && d < rsp_d) begin
                    e_psel = 1; e_pen = (d >= 2); e_wr = t_wr; e_addr = t_addr; e_wd = t_wd;
                end
                if (d == rsp_d) begin
                    e_rsp[tg] = 1'b1; e_rd = t_rd; e_err = t_err;
                end
            end
            chk("req_ready", bus.req_ready, e_ready);
            chk("psel", bus.psel, e_psel);
            chk("penable", bus.penable, e_pen);
            chk("pwrite", bus.pwrite, e_wr);
            chk("paddr", bus.paddr, e_addr);
            chk("pwdata", bus.pwdata, e_wd);
            chk("rsp_valid", bus.rsp_valid, e_rsp);
            chk("rsp_rdata", bus.rsp_rdata, e_rd);
            chk("rsp_err", bus.rsp_err, e_err);
            m_ready = e_ready;
        end
    end

    // APB slave: completes exactly after the model's chosen wait count, noise elsewhere.
    task automatic drive_slave();
        int  dd;
        bit  acc;
        dd  = cyc + 1 - t_acc;
        acc = (cyc + 1 < idle_at) && !t_mis && dd >= 2 && dd < rsp_d;
        if (acc && !t_to && dd == 2 + t_w) begin
            bus.pready  = 1'b1;
            bus.pslverr = t_slv;
            bus.prdata  = t_slv ? 32'h0 : (t_wr ? $urandom : t_prd);
        end else begin
            bus.pready  = acc ? 1'b0 : 1'($urandom_range(0, 1));
            bus.pslverr = 1'($urandom_range(0, 1));
            bus.prdata  = $urandom;
        end
    endtask

    function automatic logic [11:0] rnd_addr();
        logic [11:0] a;
        a = {4'h0, 6'($urandom_range(0, 15)), 2'b00};
        if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    task automatic issue(input int i, input bit wr, input logic [11:0] a, input logic [31:0] wd);
        bus.req_valid[i]          = 1'b1;
        bus.req_write[i]          = wr;
        bus.req_addr[12*i +: 12]  = a;
        bus.req_wdata[32*i +: 32] = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (m_ready[i] && !hold[i]) bus.req_valid[i] = 1'b0;
            if (rnd) begin
                if (bus.req_valid[i] && !m_ready[i]) begin
                    if ($urandom_range(0, 19) == 0) bus.req_valid[i] = 1'b0;
                end else if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                    issue(i, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
                end
            end
        end
        m_ready = '0;
        drive_slave();
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int bound, output int n);
        n = 0;
        while (bus.rsp_valid == '0 && n < bound) begin
            tick(); smp(); n++;
        end
        if (bus.rsp_valid == '0) begin
            total++; bad++;
            $display("FAIL wait_rsp: no response within %0d cycles", bound);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        oh2i = -1;
        for (int i = 0; i < N; i++) if (v[i]) oh2i = i;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int got[$];
        int guard;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        bus.req_valid = '1; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.pready = 1'b1; bus.pslverr = 1'b0; bus.prdata = 32'h0;

        // Reset state, with every requester already asking.
        repeat (3) @(posedge clk);
        smp();
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        bus.req_valid = '0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        run = 1'b1;

        // Fairness: four held requesters, eight transfers.
        force_w = 0; force_err = 0;
        tick();
        hold = '1;
        for (int i = 0; i < N; i++) issue(i, 1'b0, 12'(4 * i), 32'h0);
        guard = 0;
        while (got.size() < 8 && guard < 100) begin
            smp();
            if (bus.rsp_valid != '0) got.push_back(oh2i(bus.rsp_valid));
            tick();
            guard++;
        end
        hold = '0;
        bus.req_valid = '0;
        chk("fair_count", got.size(), 8);
        for (int k = 0; k < got.size(); k++) chk($sformatf("fair_%0d", k), got[k], k % 4);

        // Single zero-wait read by requester 0.
        mem[0] = 32'h1234ABCD;
        tick(); issue(0, 1'b0, 12'h000, 32'h0); smp();
        chk("rd_c0_ready", bus.req_ready, 4'b0001);
        tick(); smp();
        chk("rd_c1_psel", bus.psel, 1); chk("rd_c1_pen", bus.penable, 0);
        tick(); smp();
        chk("rd_c2_psel", bus.psel, 1); chk("rd_c2_pen", bus.penable, 1);
        tick(); smp();
        chk("rd_c3_rsp", bus.rsp_valid, 4'b0001);
        chk("rd_c3_rdata", bus.rsp_rdata, 32'h1234ABCD);
        chk("rd_c3_err", bus.rsp_err, 0);

        // Write then read back by requester 2.
        tick(); issue(2, 1'b1, 12'h010, 32'hFFFF0000); smp();
        chk("wr_ready", bus.req_ready, 4'b0100);
        tick(); smp();
        chk("wr_c1_pwrite", bus.pwrite, 1); chk("wr_c1_pwdata", bus.pwdata, 32'hFFFF0000);
        chk("wr_c1_paddr", bus.paddr, 12'h010);
        tick(); smp();
        chk("wr_c2_pwrite", bus.pwrite, 1); chk("wr_c2_pwdata", bus.pwdata, 32'hFFFF0000);
        tick(); smp();
        chk("wr_c3_rsp", bus.rsp_valid, 4'b0100); chk("wr_c3_rdata", bus.rsp_rdata, 0);
        tick(); issue(2, 1'b0, 12'h010, 32'h5A5A5A5A); smp();
        wait_rsp(10, n);
        chk("rb_cycle", n, 3);
        chk("rb_rdata", bus.rsp_rdata, 32'hFFFF0000);

        // Misaligned read by requester 1.
        tick(); issue(1, 1'b0, 12'h006, 32'h0); smp();
        chk("mis_ready", bus.req_ready, 4'b0010); chk("mis_c0_psel", bus.psel, 0);
        tick(); smp();
        chk("mis_rsp", bus.rsp_valid, 4'b0010); chk("mis_err", bus.rsp_err, 1);
        chk("mis_rdata", bus.rsp_rdata, 0); chk("mis_c1_psel", bus.psel, 0);

        // Fifteen wait states: pready on what would be the last timeout cycle still completes.
        force_w = 15; force_err = 0; mem[3] = 32'hCAFE0001;
        tick(); tick(); issue(3, 1'b0, 12'h00C, 32'h0); smp();
        wait_rsp(40, n);
        chk("w15_cycle", n, 18); chk("w15_err", bus.rsp_err, 0);
        chk("w15_rdata", bus.rsp_rdata, 32'hCAFE0001);

        // Long stall: timeout abort, or eventual completion with pslverr.
        force_w = 20; force_err = 1;
        tick(); issue(3, 1'b0, 12'h008, 32'h0); smp();
        wait_rsp(40, n);
`ifdef PCIE_CFG_ARB_TIMEOUT_EN
        chk("stall_cycle", n, 18);
`else
        chk("stall_cycle", n, 23);
`endif
        chk("stall_err", bus.rsp_err, 1); chk("stall_rdata", bus.rsp_rdata, 0);

        // Asynchronous reset in the middle of ACCESS.
        force_w = 30; force_err = 0;
        tick(); issue(1, 1'b0, 12'h004, 32'h0); smp();
        repeat (5) begin tick(); smp(); end
        chk("pre_rst_pen", bus.penable, 1);
        #1;
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        chk("arst_psel", bus.psel, 0); chk("arst_pen", bus.penable, 0);
        chk("arst_paddr", bus.paddr, 0); chk("arst_rsp", bus.rsp_valid, 0);
        idle_at = 0; last = N - 1; m_ready = '0;
        force_w = 0;
        bus.req_valid = '1;
        repeat (2) begin
            @(negedge clk); #1;
            chk("arst_no_rsp", bus.rsp_valid, 0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        run = 1'b1;
        smp();
        chk("post_rst_ready", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;

        // Random traffic against the model.
        force_w = -1; force_err = -1;
        rnd = 1'b1;
        repeat (3000) tick();
        rnd = 1'b0;
        tick();
        bus.req_valid = '0;
        repeat (40) tick();
        smp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
